cp0_access_ctrl: RTL and testbench
==================================

Name: cp0_access_ctrl

Overview:
Sequencer in front of the CP0 register file: serialises mtc0/mfc0 from ALU0 and TLB instructions (TLBR/TLBWI/TLBWR/TLBP) onto the single CP0 read/write port. Enforces post-write hazard bubbles, blocks interrupt sampling while Status/Cause are in flux, and drops in-flight work on exception flush.

Parameters:
TLB_LAT, 2, cycles from tlb_start to TLB result valid (1..7)
HAZ_CYCLES, 2, bubble cycles after a hazard-class CP0 write (0..7)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (asserted at 0)
exc_flush  in  1  exception/ERET commit this cycle; preempts everything
alu_req_valid  in  1  ALU0 CP0 request valid
alu_req_ready  out  1  request accepted when valid&ready
alu_req_we  in  1  1=mtc0, 0=mfc0
alu_req_addr  in  5  CP0 register number
alu_req_sel  in  3  CP0 select
alu_req_wdata  in  32  mtc0 data
alu_rsp_valid  out  1  mfc0 data valid (single-cycle pulse)
alu_rsp_rdata  out  32  mfc0 data
tlb_op_valid  in  1  TLB instruction valid
tlb_op_ready  out  1  TLB instruction accepted
tlb_op_type  in  2  0 TLBR, 1 TLBWI, 2 TLBWR, 3 TLBP
tlb_start  out  1  one-cycle pulse starting TLB array access
tlb_wb_en  out  1  one-cycle pulse: write TLB result into CP0 (TLBR/TLBP only)
cp0_we  out  1  CP0 write enable
cp0_addr  out  5  CP0 read/write address
cp0_sel  out  3  CP0 select
cp0_wdata  out  32  CP0 write data
cp0_rdata  in  32  CP0 combinational read data
int_block  out  1  high: interrupt sampling suppressed

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0; ready outputs 0 during reset, 1 in IDLE.
- States: IDLE, RD (mfc0), TLB_EXEC, TLB_WB, HAZ.
- IDLE: tlb_op_valid wins over alu_req_valid; the loser's ready=0. tlb_op_ready=alu_req_ready=0 outside IDLE.
- mtc0 accept: cp0_we=1 same cycle (addr/sel/wdata driven combinationally from request). Hazard-class targets (Status 12/0, Cause 13/0, EntryHi 10/0, Compare 11/0) -> HAZ with counter=HAZ_CYCLES (HAZ_CYCLES=0 -> IDLE). Other targets -> IDLE.
- mfc0 accept: latch addr/sel -> RD; in RD drive cp0_addr/sel, register cp0_rdata; alu_rsp_valid pulses the cycle after RD. Latency accept->rsp = 2 cycles.
- TLB accept: tlb_start pulse, counter=TLB_LAT -> TLB_EXEC; decrement to 0. TLBR/TLBP -> TLB_WB (tlb_wb_en=1 one cycle) -> HAZ. TLBWI/TLBWR -> IDLE.
- HAZ: decrement counter, ready=0, int_block=1; exits to IDLE on the cycle counter reaches 0.
- int_block also 1 in TLB_EXEC and TLB_WB.
- exc_flush: highest priority in any state. Same-cycle accept is suppressed (ready=0, cp0_we=0, tlb_start=0). Next state IDLE, counters cleared, no alu_rsp_valid, no tlb_wb_en. A flush arriving in RD drops the response.
- Async reset mid-operation: immediate return to IDLE; no pulses emitted.

Optional Feature:
CP0_FWD_EN: when defined, a 5/3-bit tag plus 32-bit data of the last mtc0 is kept. An mfc0 with matching addr/sel is accepted in HAZ. Its response (2-cycle latency) returns the forwarded data. HAZ countdown continues; state returns to HAZ or IDLE afterwards. Without the macro, mfc0 stalls until HAZ ends.

Decomposition:
- Shared package: state enum, tlb op enum, CP0 address/select constants, hazard-class predicate function.
- One sub-module, cp0_down_counter (load, decrement, zero flag), is natural and reused for the TLB_EXEC and HAZ countdowns.

Test Plan:
- mtc0 Status=0x0000FF01 -> cp0_we 1 cycle, addr 12, sel 0; ready=0 and int_block=1 for exactly 2 cycles; then ready=1.
- mfc0 Count (9/0) with cp0_rdata=0x1234ABCD -> alu_rsp_valid 2 cycles after accept, rdata=0x1234ABCD.
- TLBP with TLB_LAT=2 -> tlb_start at cycle 0, tlb_wb_en at cycle 3, then 2 HAZ cycles. TLBWI -> no tlb_wb_en, IDLE at cycle 3.
- tlb_op_valid and alu_req_valid in the same IDLE cycle -> tlb_op_ready=1, alu_req_ready=0. ALU request is accepted on the first IDLE cycle afterwards.
- exc_flush in the same cycle as an mtc0 -> cp0_we=0, no hazard. exc_flush during TLB_EXEC of TLBR -> no tlb_wb_en, IDLE next cycle.
- With CP0_FWD_EN: mtc0 EntryHi=0xDEAD0000, then an immediate mfc0 EntryHi -> rsp 0xDEAD0000 during HAZ. Without the macro, mfc0 is accepted only after HAZ ends.

Source files
------------

// File: rtl/cp0_access_ctrl_pkg.sv
// Shared types, CP0 register constants and decode helpers for the CP0 access sequencer.
package cp0_access_ctrl_pkg;

  localparam int unsigned CP0_ADDR_W = 5;
  localparam int unsigned CP0_SEL_W  = 3;
  localparam int unsigned CP0_DATA_W = 32;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_TLB_EXEC = 3'd2,
    ST_TLB_WB   = 3'd3,
    ST_HAZ      = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    TLB_OP_TLBR  = 2'd0,
    TLB_OP_TLBWI = 2'd1,
    TLB_OP_TLBWR = 2'd2,
    TLB_OP_TLBP  = 2'd3
  } tlb_op_e;

  typedef struct packed {
    logic [CP0_ADDR_W-1:0] addr;
    logic [CP0_SEL_W-1:0]  sel;
  } cp0_reg_t;

  localparam logic [CP0_ADDR_W-1:0] CP0_COUNT   = 5'd9;
  localparam logic [CP0_ADDR_W-1:0] CP0_ENTRYHI = 5'd10;
  localparam logic [CP0_ADDR_W-1:0] CP0_COMPARE = 5'd11;
  localparam logic [CP0_ADDR_W-1:0] CP0_STATUS  = 5'd12;
  localparam logic [CP0_ADDR_W-1:0] CP0_CAUSE   = 5'd13;

  // Writes to these registers change interrupt/translation state and need bubbles.
  function automatic logic is_hazard_reg(input logic [CP0_ADDR_W-1:0] addr,
                                         input logic [CP0_SEL_W-1:0]  sel);
    return (sel == '0) &&
           ((addr == CP0_STATUS) || (addr == CP0_CAUSE) ||
            (addr == CP0_ENTRYHI) || (addr == CP0_COMPARE));
  endfunction

  // TLBR and TLBP return results that must be written back into CP0.
  function automatic logic tlb_op_writes_cp0(input tlb_op_e op);
    return (op == TLB_OP_TLBR) || (op == TLB_OP_TLBP);
  endfunction

endpackage

// File: rtl/cp0_down_counter.sv
// Loadable saturating down-counter used for the TLB latency and hazard bubble countdowns.
module cp0_down_counter
  import cp0_access_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/cp0_access_ctrl.sv
// Serialises ALU mtc0/mfc0 and TLB instructions onto the single CP0 port.
// Optional build macro CP0_FWD_EN: forward the last mtc0 value to a matching mfc0 during HAZ.
module cp0_access_ctrl
  import cp0_access_ctrl_pkg::*;
#(
  parameter int unsigned TLB_LAT    = 2,
  parameter int unsigned HAZ_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_flush,
  input  logic                  alu_req_valid,
  output logic                  alu_req_ready,
  input  logic                  alu_req_we,
  input  logic [CP0_ADDR_W-1:0] alu_req_addr,
  input  logic [CP0_SEL_W-1:0]  alu_req_sel,
  input  logic [CP0_DATA_W-1:0] alu_req_wdata,
  output logic                  alu_rsp_valid,
  output logic [CP0_DATA_W-1:0] alu_rsp_rdata,
  input  logic                  tlb_op_valid,
  output logic                  tlb_op_ready,
  input  logic [1:0]            tlb_op_type,
  output logic                  tlb_start,
  output logic                  tlb_wb_en,
  output logic                  cp0_we,
  output logic [CP0_ADDR_W-1:0] cp0_addr,
  output logic [CP0_SEL_W-1:0]  cp0_sel,
  output logic [CP0_DATA_W-1:0] cp0_wdata,
  input  logic [CP0_DATA_W-1:0] cp0_rdata,
  output logic                  int_block
);

  localparam logic HAZ_EN = (HAZ_CYCLES != 0);

  state_e                  state_q, state_d;
  tlb_op_e                 tlb_op_q;
  cp0_reg_t                rd_tag_q;
  logic                    rsp_valid_q;
  logic [CP0_DATA_W-1:0]   rsp_rdata_q;
  logic                    int_block_q;

  logic                    active;
  logic                    in_idle;
  logic                    tlb_acc;
  logic                    alu_acc;
  logic                    mtc0_acc;
  logic                    mfc0_acc;
  logic                    fwd_hit;
  logic                    fwd_acc;
  logic                    fwd_pend;
  logic [CP0_DATA_W-1:0]   fwd_data;

  logic [CNT_W-1:0]        tlb_cnt, haz_cnt;
  logic                    tlb_zero, haz_zero;
  logic                    tlb_last, haz_last;
  logic                    haz_load;

  // Handshake decode: flush and reset suppress every accept.
  assign active    = rst && !exc_flush;
  assign in_idle   = (state_q == ST_IDLE);
  assign tlb_op_ready  = active && in_idle;
  assign alu_req_ready = active && ((in_idle && !tlb_op_valid) || fwd_hit);
  assign tlb_acc   = tlb_op_valid && tlb_op_ready;
  assign alu_acc   = alu_req_valid && alu_req_ready;
  assign mtc0_acc  = alu_acc && in_idle && alu_req_we;
  assign mfc0_acc  = alu_acc && in_idle && !alu_req_we;
  assign fwd_acc   = alu_acc && (state_q == ST_HAZ);

  assign tlb_last  = tlb_zero || (tlb_cnt == CNT_W'(1));
  assign haz_last  = haz_zero || (haz_cnt == CNT_W'(1));
  assign haz_load  = (mtc0_acc && is_hazard_reg(alu_req_addr, alu_req_sel)) ||
                     ((state_q == ST_TLB_WB) && active);

  cp0_down_counter #(.W(CNT_W)) u_tlb_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (exc_flush),
    .load     (tlb_acc),
    .load_val (CNT_W'(TLB_LAT)),
    .dec      (state_q == ST_TLB_EXEC),
    .count    (tlb_cnt),
    .zero     (tlb_zero)
  );

  cp0_down_counter #(.W(CNT_W)) u_haz_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (exc_flush),
    .load     (haz_load),
    .load_val (CNT_W'(HAZ_CYCLES)),
    .dec      (state_q == ST_HAZ),
    .count    (haz_cnt),
    .zero     (haz_zero)
  );

`ifdef CP0_FWD_EN
  logic                  fwd_vld_q;
  cp0_reg_t              fwd_tag_q;
  logic [CP0_DATA_W-1:0] fwd_data_q;
  logic                  fwd_pend_q;

  // Tag/data of the most recent mtc0, plus a one-deep forwarded-response pipe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_vld_q  <= 1'b0;
      fwd_tag_q  <= '0;
      fwd_data_q <= '0;
      fwd_pend_q <= 1'b0;
    end else begin
      if (mtc0_acc) begin
        fwd_vld_q  <= 1'b1;
        fwd_tag_q  <= '{addr: alu_req_addr, sel: alu_req_sel};
        fwd_data_q <= alu_req_wdata;
      end
      fwd_pend_q <= fwd_acc;
    end
  end

  assign fwd_hit  = (state_q == ST_HAZ) && fwd_vld_q && !alu_req_we &&
                    (fwd_tag_q == cp0_reg_t'({alu_req_addr, alu_req_sel}));
  assign fwd_pend = fwd_pend_q;
  assign fwd_data = fwd_data_q;
`else
  assign fwd_hit  = 1'b0;
  assign fwd_pend = 1'b0;
  assign fwd_data = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    if (exc_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tlb_acc) begin
            state_d = ST_TLB_EXEC;
          end else if (mtc0_acc && HAZ_EN && is_hazard_reg(alu_req_addr, alu_req_sel)) begin
            state_d = ST_HAZ;
          end else if (mfc0_acc) begin
            state_d = ST_RD;
          end
        end
        ST_RD:       state_d = ST_IDLE;
        ST_TLB_EXEC: begin
          if (tlb_last) begin
            state_d = tlb_op_writes_cp0(tlb_op_q) ? ST_TLB_WB : ST_IDLE;
          end
        end
        ST_TLB_WB:   state_d = HAZ_EN ? ST_HAZ : ST_IDLE;
        ST_HAZ: begin
          if (haz_last) begin
            state_d = ST_IDLE;
          end
        end
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Request capture, response register and interrupt-block flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tlb_op_q    <= TLB_OP_TLBR;
      rd_tag_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      int_block_q <= 1'b0;
    end else begin
      if (tlb_acc) begin
        tlb_op_q <= tlb_op_e'(tlb_op_type);
      end
      if (mfc0_acc) begin
        rd_tag_q <= '{addr: alu_req_addr, sel: alu_req_sel};
      end
      rsp_valid_q <= 1'b0;
      if (!exc_flush) begin
        if (state_q == ST_RD) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= cp0_rdata;
        end else if (fwd_pend) begin
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= fwd_data;
        end
      end
      int_block_q <= (state_d == ST_TLB_EXEC) || (state_d == ST_TLB_WB) ||
                     (state_d == ST_HAZ);
    end
  end

  // CP0 port: request fields on an mtc0 accept, latched tag while reading.
  always_comb begin
    cp0_we    = 1'b0;
    cp0_addr  = '0;
    cp0_sel   = '0;
    cp0_wdata = '0;
    if (mtc0_acc) begin
      cp0_we    = 1'b1;
      cp0_addr  = alu_req_addr;
      cp0_sel   = alu_req_sel;
      cp0_wdata = alu_req_wdata;
    end else if (state_q == ST_RD) begin
      cp0_addr  = rd_tag_q.addr;
      cp0_sel   = rd_tag_q.sel;
    end
  end

  assign tlb_start     = tlb_acc;
  assign tlb_wb_en     = active && (state_q == ST_TLB_WB);
  assign alu_rsp_valid = rsp_valid_q;
  assign alu_rsp_rdata = rsp_rdata_q;
  assign int_block     = int_block_q;

endmodule

// File: tb/tb_cp0_access_ctrl.sv
// Directed bench for cp0_access_ctrl (TLB_LAT=2, HAZ_CYCLES=2); honours CP0_FWD_EN if defined.
module tb_cp0_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_flush;
  logic        alu_req_valid;
  logic        alu_req_ready;
  logic        alu_req_we;
  logic [4:0]  alu_req_addr;
  logic [2:0]  alu_req_sel;
  logic [31:0] alu_req_wdata;
  logic        alu_rsp_valid;
  logic [31:0] alu_rsp_rdata;
  logic        tlb_op_valid;
  logic        tlb_op_ready;
  logic [1:0]  tlb_op_type;
  logic        tlb_start;
  logic        tlb_wb_en;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [2:0]  cp0_sel;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        int_block;

  int tests = 0;
  int fails = 0;

  cp0_access_ctrl #(.TLB_LAT(2), .HAZ_CYCLES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .exc_flush     (exc_flush),
    .alu_req_valid (alu_req_valid),
    .alu_req_ready (alu_req_ready),
    .alu_req_we    (alu_req_we),
    .alu_req_addr  (alu_req_addr),
    .alu_req_sel   (alu_req_sel),
    .alu_req_wdata (alu_req_wdata),
    .alu_rsp_valid (alu_rsp_valid),
    .alu_rsp_rdata (alu_rsp_rdata),
    .tlb_op_valid  (tlb_op_valid),
    .tlb_op_ready  (tlb_op_ready),
    .tlb_op_type   (tlb_op_type),
    .tlb_start     (tlb_start),
    .tlb_wb_en     (tlb_wb_en),
    .cp0_we        (cp0_we),
    .cp0_addr      (cp0_addr),
    .cp0_sel       (cp0_sel),
    .cp0_wdata     (cp0_wdata),
    .cp0_rdata     (cp0_rdata),
    .int_block     (int_block)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alu_drive(input logic v, input logic we, input logic [4:0] a,
                           input logic [2:0] s, input logic [31:0] d);
    alu_req_valid = v;
    alu_req_we    = we;
    alu_req_addr  = a;
    alu_req_sel   = s;
    alu_req_wdata = d;
  endtask

  initial begin
    rst           = 1'b0;
    exc_flush     = 1'b0;
    tlb_op_valid  = 1'b0;
    tlb_op_type   = 2'd0;
    cp0_rdata     = 32'h0;
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);

    // Reset state
    tick();
    check("rst_alu_ready", 32'(alu_req_ready), 32'd0);
    check("rst_tlb_ready", 32'(tlb_op_ready), 32'd0);
    check("rst_int_block", 32'(int_block), 32'd0);
    check("rst_rsp_valid", 32'(alu_rsp_valid), 32'd0);
    check("rst_cp0_we", 32'(cp0_we), 32'd0);
    rst = 1'b1;
    #1;
    check("idle_alu_ready", 32'(alu_req_ready), 32'd1);
    check("idle_tlb_ready", 32'(tlb_op_ready), 32'd1);

    // mtc0 Status: one write then two bubble cycles
    tick();
    alu_drive(1'b1, 1'b1, 5'd12, 3'd0, 32'h0000FF01);
    #1;
    check("mtc0_ready", 32'(alu_req_ready), 32'd1);
    check("mtc0_we", 32'(cp0_we), 32'd1);
    check("mtc0_addr", 32'(cp0_addr), 32'd12);
    check("mtc0_sel", 32'(cp0_sel), 32'd0);
    check("mtc0_wdata", cp0_wdata, 32'h0000FF01);
    tick();
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    #1;
    check("haz1_we", 32'(cp0_we), 32'd0);
    check("haz1_ready", 32'(alu_req_ready), 32'd0);
    check("haz1_int_block", 32'(int_block), 32'd1);
    tick();
    check("haz2_ready", 32'(alu_req_ready), 32'd0);
    check("haz2_int_block", 32'(int_block), 32'd1);
    tick();
    check("haz_end_ready", 32'(alu_req_ready), 32'd1);
    check("haz_end_int_block", 32'(int_block), 32'd0);

    // mfc0 Count: response two cycles after accept
    alu_drive(1'b1, 1'b0, 5'd9, 3'd0, 32'h0);
    cp0_rdata = 32'h1234ABCD;
    #1;
    check("mfc0_ready", 32'(alu_req_ready), 32'd1);
    check("mfc0_no_we", 32'(cp0_we), 32'd0);
    tick();
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    #1;
    check("rd_addr", 32'(cp0_addr), 32'd9);
    check("rd_rsp_early", 32'(alu_rsp_valid), 32'd0);
    tick();
    check("mfc0_rsp_valid", 32'(alu_rsp_valid), 32'd1);
    check("mfc0_rsp_data", alu_rsp_rdata, 32'h1234ABCD);
    tick();
    check("mfc0_rsp_pulse", 32'(alu_rsp_valid), 32'd0);

    // TLBP: start at c0, writeback at c3, then two HAZ cycles
    tlb_op_valid = 1'b1;
    tlb_op_type  = 2'd3;
    #1;
    check("tlbp_ready", 32'(tlb_op_ready), 32'd1);
    check("tlbp_start", 32'(tlb_start), 32'd1);
    tick();
    tlb_op_valid = 1'b0;
    #1;
    check("tlbp_c1_start", 32'(tlb_start), 32'd0);
    check("tlbp_c1_int_block", 32'(int_block), 32'd1);
    check("tlbp_c1_wb", 32'(tlb_wb_en), 32'd0);
    tick();
    check("tlbp_c2_wb", 32'(tlb_wb_en), 32'd0);
    tick();
    check("tlbp_c3_wb", 32'(tlb_wb_en), 32'd1);
    check("tlbp_c3_int_block", 32'(int_block), 32'd1);
    tick();
    check("tlbp_c4_wb", 32'(tlb_wb_en), 32'd0);
    check("tlbp_c4_ready", 32'(tlb_op_ready), 32'd0);
    check("tlbp_c4_int_block", 32'(int_block), 32'd1);
    tick();
    check("tlbp_c5_int_block", 32'(int_block), 32'd1);
    tick();
    check("tlbp_c6_ready", 32'(tlb_op_ready), 32'd1);
    check("tlbp_c6_int_block", 32'(int_block), 32'd0);

    // TLBWI: no writeback, idle at c3
    tlb_op_valid = 1'b1;
    tlb_op_type  = 2'd1;
    #1;
    check("tlbwi_start", 32'(tlb_start), 32'd1);
    tick();
    tlb_op_valid = 1'b0;
    tick();
    check("tlbwi_c2_wb", 32'(tlb_wb_en), 32'd0);
    check("tlbwi_c2_ready", 32'(tlb_op_ready), 32'd0);
    tick();
    check("tlbwi_c3_wb", 32'(tlb_wb_en), 32'd0);
    check("tlbwi_c3_ready", 32'(tlb_op_ready), 32'd1);
    check("tlbwi_c3_int_block", 32'(int_block), 32'd0);

    // Arbitration: TLB wins, ALU waits for the next IDLE cycle
    tlb_op_valid = 1'b1;
    tlb_op_type  = 2'd1;
    alu_drive(1'b1, 1'b1, 5'd9, 3'd0, 32'h00000077);
    #1;
    check("arb_tlb_ready", 32'(tlb_op_ready), 32'd1);
    check("arb_alu_ready", 32'(alu_req_ready), 32'd0);
    check("arb_we", 32'(cp0_we), 32'd0);
    tick();
    tlb_op_valid = 1'b0;
    #1;
    check("arb_c1_alu_ready", 32'(alu_req_ready), 32'd0);
    tick();
    check("arb_c2_alu_ready", 32'(alu_req_ready), 32'd0);
    tick();
    check("arb_c3_alu_ready", 32'(alu_req_ready), 32'd1);
    check("arb_c3_we", 32'(cp0_we), 32'd1);
    check("arb_c3_wdata", cp0_wdata, 32'h00000077);
    tick();
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    #1;
    check("arb_count_no_haz", 32'(int_block), 32'd0);
    check("arb_count_ready", 32'(alu_req_ready), 32'd1);

    // Flush with an mtc0 Status: nothing accepted, no hazard
    exc_flush = 1'b1;
    alu_drive(1'b1, 1'b1, 5'd12, 3'd0, 32'h00000001);
    #1;
    check("flush_alu_ready", 32'(alu_req_ready), 32'd0);
    check("flush_we", 32'(cp0_we), 32'd0);
    tick();
    exc_flush = 1'b0;
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    #1;
    check("flush_no_haz", 32'(int_block), 32'd0);
    check("flush_ready_after", 32'(alu_req_ready), 32'd1);

    // Flush during TLB_EXEC of TLBR: no writeback, idle next cycle
    tlb_op_valid = 1'b1;
    tlb_op_type  = 2'd0;
    tick();
    tlb_op_valid = 1'b0;
    exc_flush    = 1'b1;
    #1;
    check("tlbr_flush_start", 32'(tlb_start), 32'd0);
    check("tlbr_exec_int_block", 32'(int_block), 32'd1);
    tick();
    exc_flush = 1'b0;
    #1;
    check("tlbr_flush_idle", 32'(tlb_op_ready), 32'd1);
    check("tlbr_flush_int_block", 32'(int_block), 32'd0);
    tick();
    check("tlbr_flush_wb1", 32'(tlb_wb_en), 32'd0);
    tick();
    check("tlbr_flush_wb2", 32'(tlb_wb_en), 32'd0);

    // Flush in RD drops the response
    alu_drive(1'b1, 1'b0, 5'd9, 3'd0, 32'h0);
    cp0_rdata = 32'hCAFEF00D;
    tick();
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    exc_flush = 1'b1;
    tick();
    exc_flush = 1'b0;
    #1;
    check("rd_flush_rsp", 32'(alu_rsp_valid), 32'd0);
    tick();
    check("rd_flush_rsp_late", 32'(alu_rsp_valid), 32'd0);

    // Async reset mid-TLBR: immediate idle, no writeback afterwards
    tlb_op_valid = 1'b1;
    tlb_op_type  = 2'd0;
    tick();
    tlb_op_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst_int_block", 32'(int_block), 32'd0);
    check("arst_tlb_ready", 32'(tlb_op_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    check("arst_wb1", 32'(tlb_wb_en), 32'd0);
    check("arst_ready", 32'(tlb_op_ready), 32'd1);
    tick();
    check("arst_wb2", 32'(tlb_wb_en), 32'd0);

    // mtc0 EntryHi followed immediately by mfc0 EntryHi
    cp0_rdata = 32'h55555555;
    alu_drive(1'b1, 1'b1, 5'd10, 3'd0, 32'hDEAD0000);
    tick();
    alu_drive(1'b1, 1'b0, 5'd10, 3'd0, 32'h0);
    #1;
`ifdef CP0_FWD_EN
    check("fwd_accept_in_haz", 32'(alu_req_ready), 32'd1);
    tick();
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    #1;
    check("fwd_haz_continues", 32'(int_block), 32'd1);
    check("fwd_rsp_early", 32'(alu_rsp_valid), 32'd0);
    tick();
    check("fwd_rsp_valid", 32'(alu_rsp_valid), 32'd1);
    check("fwd_rsp_data", alu_rsp_rdata, 32'hDEAD0000);
    check("fwd_idle_after", 32'(int_block), 32'd0);
`else
    check("nofwd_stall_c1", 32'(alu_req_ready), 32'd0);
    tick();
    check("nofwd_stall_c2", 32'(alu_req_ready), 32'd0);
    check("nofwd_int_block", 32'(int_block), 32'd1);
    tick();
    check("nofwd_accept_c3", 32'(alu_req_ready), 32'd1);
    tick();
    alu_drive(1'b0, 1'b0, 5'd0, 3'd0, 32'h0);
    #1;
    check("nofwd_rd_addr", 32'(cp0_addr), 32'd10);
    check("nofwd_rsp_early", 32'(alu_rsp_valid), 32'd0);
    tick();
    check("nofwd_rsp_valid", 32'(alu_rsp_valid), 32'd1);
    check("nofwd_rsp_data", alu_rsp_rdata, 32'h55555555);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
